// File: rtl/mult_pkg.sv
// Shared encodings between mult_control and mult_datapath: partial-product and shift selects.
// Pure declarations; no timing or flow control of its own.
package mult_pkg;

    // input_sel: which operand halves feed the nibble multiplier
    typedef enum logic [1:0] {
        SEL_LL = 2'd0,
        SEL_LH = 2'd1,
        SEL_HL = 2'd2,
        SEL_HH = 2'd3
    } mult_in_sel_e;

    // shift_sel: placement of the partial product within the accumulator
    typedef enum logic [1:0] {
        SHIFT_0    = 2'd0,
        SHIFT_NIB  = 2'd1,
        SHIFT_FULL = 2'd2,
        SHIFT_ZERO = 2'd3
    } mult_shift_sel_e;

    localparam int MULT_DATA_W_DEF = 8;

    // Low or high half of an operand; hi=1 selects the upper NIB bits.
    function automatic logic [MULT_DATA_W_DEF/2-1:0] mult_half(
        input logic [MULT_DATA_W_DEF-1:0] v,
        input logic                       hi
    );
        return hi ? v[MULT_DATA_W_DEF-1:MULT_DATA_W_DEF/2] : v[MULT_DATA_W_DEF/2-1:0];
    endfunction

endpackage

// File: rtl/mult_datapath_if.sv
// Command/result bundle between the multiply controller (master) and the datapath (slave).
// Level signals sampled every clock; no handshake, the controller owns sequencing.
interface mult_datapath_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0]   dataa;
    logic [DATA_W-1:0]   datab;
    logic [1:0]          input_sel;
    logic [1:0]          shift_sel;
    logic                clk_ena;
    logic                sclr_n;
    logic                done;
    logic [1:0]          count;
    logic [2*DATA_W-1:0] product;
    logic                result_valid;

    modport master (
        output dataa, datab, input_sel, shift_sel, clk_ena, sclr_n, done,
        input  count, product, result_valid
    );

    modport slave (
        input  dataa, datab, input_sel, shift_sel, clk_ena, sclr_n, done,
        output count, product, result_valid
    );
endinterface

// File: rtl/mult_nibble_mul.sv
// Unsigned NIB x NIB combinational multiplier giving a 2*NIB bit product.
// Zero latency, no flow control.
module mult_nibble_mul #(
    parameter int NIB = 4
) (
    input  logic [NIB-1:0]   i_a,
    input  logic [NIB-1:0]   i_b,
    output logic [2*NIB-1:0] o_p
);
    logic [2*NIB-1:0] w_a_ext;
    logic [2*NIB-1:0] w_b_ext;

    assign w_a_ext = {{NIB{1'b0}}, i_a};
    assign w_b_ext = {{NIB{1'b0}}, i_b};
    assign o_p     = w_a_ext * w_b_ext;
endmodule

// File: rtl/mult_datapath.sv
// Shift-and-add datapath for the sequential multiplier; 1-cycle registered update, no backpressure.
// MULT_DP_OPLATCH_EN: capture operands during the clear cycle so they may change afterwards.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic            clk,
    input  logic            reset_a,
    mult_datapath_if.slave  bus
);
    localparam int NIB  = DATA_W / 2;
    localparam int PW   = 2 * DATA_W;

    logic [DATA_W-1:0] w_opa;
    logic [DATA_W-1:0] w_opb;
    logic [NIB-1:0]    w_a_half;
    logic [NIB-1:0]    w_b_half;
    logic [DATA_W-1:0] w_pp;
    logic [PW-1:0]     w_pp_ext;
    logic [PW-1:0]     w_term;
    logic [PW-1:0]     w_sum;

    logic [PW-1:0]     r_product;
    logic [1:0]        r_count;
    logic              r_result_valid;

`ifdef MULT_DP_OPLATCH_EN
    logic [DATA_W-1:0] r_opa;
    logic [DATA_W-1:0] r_opb;

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            r_opa <= '0;
            r_opb <= '0;
        end else if (!bus.sclr_n) begin
            r_opa <= bus.dataa;
            r_opb <= bus.datab;
        end
    end

    assign w_opa = r_opa;
    assign w_opb = r_opb;
`else
    assign w_opa = bus.dataa;
    assign w_opb = bus.datab;
`endif

    always_comb begin
        w_a_half = w_opa[NIB-1:0];
        w_b_half = w_opb[NIB-1:0];
        case (bus.input_sel)
            SEL_LL: begin
                w_a_half = w_opa[NIB-1:0];
                w_b_half = w_opb[NIB-1:0];
            end
            SEL_LH: begin
                w_a_half = w_opa[NIB-1:0];
                w_b_half = w_opb[DATA_W-1:NIB];
            end
            SEL_HL: begin
                w_a_half = w_opa[DATA_W-1:NIB];
                w_b_half = w_opb[NIB-1:0];
            end
            default: begin
                w_a_half = w_opa[DATA_W-1:NIB];
                w_b_half = w_opb[DATA_W-1:NIB];
            end
        endcase
    end

    mult_nibble_mul #(
        .NIB (NIB)
    ) u_nibble_mul (
        .i_a (w_a_half),
        .i_b (w_b_half),
        .o_p (w_pp)
    );

    assign w_pp_ext = {{DATA_W{1'b0}}, w_pp};

    always_comb begin
        w_term = '0;
        case (bus.shift_sel)
            SHIFT_0:    w_term = w_pp_ext;
            SHIFT_NIB:  w_term = w_pp_ext << NIB;
            SHIFT_FULL: w_term = w_pp_ext << DATA_W;
            default:    w_term = '0;
        endcase
    end

    // Carry out of the top bit is dropped: accumulation is modulo 2^PW.
    assign w_sum = r_product + w_term;

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            r_product      <= '0;
            r_count        <= '0;
            r_result_valid <= 1'b0;
        end else if (!bus.sclr_n) begin
            r_product      <= '0;
            r_count        <= '0;
            r_result_valid <= 1'b0;
        end else begin
            if (bus.clk_ena) begin
                r_product <= w_sum;
                r_count   <= r_count + 2'd1;
            end
            if (bus.done) begin
                r_result_valid <= 1'b1;
            end
        end
    end

    assign bus.product      = r_product;
    assign bus.count        = r_count;
    assign bus.result_valid = r_result_valid;
endmodule
